// File: rtl/tt_mux_sel_seq.sv
// Mux design-select sequencer: turns a requested tile address into a timed
// select-counter reset / increment pulse train, then enables the selected design.
module tt_mux_sel_seq #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned MAX_ADDR = 384,
  parameter int unsigned PULSE_W  = 2,
  parameter int unsigned GAP_W    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_valid,
  output logic              req_ready,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              cur_valid,
  output logic              ctrl_sel_rst_n,
  output logic              ctrl_sel_inc,
  output logic              ctrl_ena
);

  localparam int unsigned TMR_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX) + 1;
  localparam int unsigned LIM_W   = ADDR_W + 1;

  localparam logic [TMR_W-1:0] PULSE_LD = TMR_W'(PULSE_W - 1);
  localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(GAP_W - 1);
  localparam logic [LIM_W-1:0] ADDR_LIM = LIM_W'(MAX_ADDR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIS,
    S_RST,
    S_RGAP,
    S_INC,
    S_IGAP,
    S_ENA
  } state_t;

  state_t              state_q, state_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [ADDR_W-1:0]   remain_q, remain_d;
  logic [ADDR_W-1:0]   tgt_q, tgt_d;
  logic                full_q, full_d;

  logic                ready_d, done_d, err_d, cur_valid_d;
  logic                rst_n_d, inc_d, ena_d;
  logic [ADDR_W-1:0]   cur_addr_d;
  logic                accept;

  assign accept = req_valid && req_ready;

  // Next state, then registered outputs derived from the next state so that
  // every control wire lines up exactly with the state it belongs to.
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    remain_d    = remain_q;
    tgt_d       = tgt_q;
    full_d      = full_q;
    cur_addr_d  = cur_addr;
    cur_valid_d = cur_valid;
    ena_d       = ctrl_ena;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if ({1'b0, req_addr} >= ADDR_LIM) begin
            err_d = 1'b1;
          end else if (cur_valid && (req_addr == cur_addr)) begin
            done_d = 1'b1;
          end else begin
            tgt_d   = req_addr;
            state_d = S_DIS;
            // Moving forward only needs the difference; anything else restarts the counter.
            if (cur_valid && (req_addr > cur_addr)) begin
              full_d   = 1'b0;
              remain_d = req_addr - cur_addr;
            end else begin
              full_d   = 1'b1;
              remain_d = req_addr;
            end
          end
        end
      end
      S_DIS: begin
        tmr_d   = PULSE_LD;
        state_d = full_q ? S_RST : S_INC;
      end
      S_RST: begin
        if (tmr_q == '0) begin
          state_d = S_RGAP;
          tmr_d   = GAP_LD;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_RGAP: begin
        if (tmr_q == '0) begin
          if (remain_q == '0) begin
            state_d = S_ENA;
          end else begin
            state_d = S_INC;
            tmr_d   = PULSE_LD;
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_INC: begin
        if (tmr_q == '0) begin
          state_d = S_IGAP;
          tmr_d   = GAP_LD;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_IGAP: begin
        if (tmr_q == '0) begin
          remain_d = remain_q - ADDR_W'(1);
          if (remain_q == ADDR_W'(1)) begin
            state_d = S_ENA;
          end else begin
            state_d = S_INC;
            tmr_d   = PULSE_LD;
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_ENA: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_IDLE);
    rst_n_d = (state_d != S_RST);
    inc_d   = (state_d == S_INC);

    case (state_d)
      S_DIS: begin
        ena_d       = 1'b0;
        cur_valid_d = 1'b0;
      end
      S_ENA: begin
        ena_d       = 1'b1;
        cur_addr_d  = tgt_q;
        cur_valid_d = 1'b1;
        done_d      = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // State and output registers; reset holds the select counter in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      tmr_q          <= '0;
      remain_q       <= '0;
      tgt_q          <= '0;
      full_q         <= 1'b1;
      req_ready      <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      cur_addr       <= '0;
      cur_valid      <= 1'b0;
      ctrl_sel_rst_n <= 1'b0;
      ctrl_sel_inc   <= 1'b0;
      ctrl_ena       <= 1'b0;
    end else begin
      state_q        <= state_d;
      tmr_q          <= tmr_d;
      remain_q       <= remain_d;
      tgt_q          <= tgt_d;
      full_q         <= full_d;
      req_ready      <= ready_d;
      done           <= done_d;
      err            <= err_d;
      cur_addr       <= cur_addr_d;
      cur_valid      <= cur_valid_d;
      ctrl_sel_rst_n <= rst_n_d;
      ctrl_sel_inc   <= inc_d;
      ctrl_ena       <= ena_d;
    end
  end

endmodule

// File: tb/tb_tt_mux_sel_seq.sv
// Bench for tt_mux_sel_seq: directed scenarios plus random requests, checked
// cycle by cycle against a pulse-train model built from the request rules.
module tb_tt_mux_sel_seq;

  localparam int unsigned AW   = 10;
  localparam int unsigned MAXA = 384;
  localparam int unsigned PW   = 2;
  localparam int unsigned GW   = 2;

  typedef struct packed {
    logic          ready;
    logic          done;
    logic          err;
    logic          cvld;
    logic          rst_n;
    logic          inc;
    logic          ena;
    logic [AW-1:0] addr;
  } ovec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] req_addr;
  logic          req_valid;
  logic          req_ready;
  logic          done;
  logic          err;
  logic [AW-1:0] cur_addr;
  logic          cur_valid;
  logic          ctrl_sel_rst_n;
  logic          ctrl_sel_inc;
  logic          ctrl_ena;

  always #5 clk = ~clk;

  tt_mux_sel_seq #(
    .ADDR_W  (AW),
    .MAX_ADDR(MAXA),
    .PULSE_W (PW),
    .GAP_W   (GW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_addr      (req_addr),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .done          (done),
    .err           (err),
    .cur_addr      (cur_addr),
    .cur_valid     (cur_valid),
    .ctrl_sel_rst_n(ctrl_sel_rst_n),
    .ctrl_sel_inc  (ctrl_sel_inc),
    .ctrl_ena      (ctrl_ena)
  );

  int          n_total = 0;
  int          n_bad   = 0;
  int          cyc     = 0;
  ovec_t       q[$];
  ovec_t       exp_now;
  int unsigned m_cur   = 0;
  bit          m_valid = 1'b0;
  bit          m_ena   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic ovec_t mk(input bit rdy, input bit dn, input bit er, input bit cv,
                               input bit rn, input bit ic, input bit en, input int unsigned ad);
    ovec_t v;
    v.ready = rdy;
    v.done  = dn;
    v.err   = er;
    v.cvld  = cv;
    v.rst_n = rn;
    v.inc   = ic;
    v.ena   = en;
    v.addr  = cv ? AW'(ad) : '0;
    return v;
  endfunction

  task automatic push_n(input ovec_t v, input int n);
    repeat (n) q.push_back(v);
  endtask

  // Expected output per cycle after an accept: disable, optional reset pulse,
  // N increment pulses, enable.
  task automatic model_accept(input int unsigned a);
    ovec_t       busy;
    bit          full;
    int unsigned n;
    busy = mk(0, 0, 0, 0, 1, 0, 0, 0);
    if (a >= MAXA) begin
      q.push_back(mk(1, 0, 1, m_valid, 1, 0, m_ena, m_cur));
    end else if (m_valid && a == m_cur) begin
      q.push_back(mk(1, 1, 0, 1, 1, 0, m_ena, m_cur));
    end else begin
      full = !(m_valid && a > m_cur);
      n    = full ? a : a - m_cur;
      q.push_back(busy);
      if (full) begin
        push_n(mk(0, 0, 0, 0, 0, 0, 0, 0), PW);
        push_n(busy, GW);
      end
      for (int i = 0; i < int'(n); i++) begin
        push_n(mk(0, 0, 0, 0, 1, 1, 0, 0), PW);
        push_n(busy, GW);
      end
      q.push_back(mk(0, 1, 0, 1, 1, 0, 1, a));
      m_cur   = a;
      m_valid = 1'b1;
      m_ena   = 1'b1;
    end
  endtask

  // Drive one cycle of inputs, then compare all outputs on the falling edge.
  task automatic cycle(input bit r, input bit v, input int unsigned a);
    ovec_t got;
    rst       = r;
    req_valid = v;
    req_addr  = AW'(a);
    if (r) begin
      q.delete();
      m_cur   = 0;
      m_valid = 1'b0;
      m_ena   = 1'b0;
      q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    end else if (v && exp_now.ready) begin
      model_accept(a);
    end
    @(negedge clk);
    cyc++;
    if (q.size() > 0) exp_now = q.pop_front();
    else exp_now = mk(1, 0, 0, m_valid, 1, 0, m_ena, m_cur);
    got = {req_ready, done, err, cur_valid, ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena, cur_addr};
    if (!exp_now.cvld) got.addr = '0;
    chk($sformatf("cyc%0d", cyc), 32'(got), 32'(exp_now));
  endtask

  // Issue one request, run it to completion and check done/err latency.
  task automatic req(input int unsigned a, input int lat_exp, input bit busy_v);
    int lat = 0;
    int c   = 0;
    int k   = 0;
    while (!exp_now.ready && k < 200) begin
      cycle(0, 0, 0);
      k++;
    end
    if (!exp_now.ready) chk("ready_wait", 32'(0), 32'(1));
    cycle(0, 1, a);
    c = 1;
    if (done || err) lat = c;
    while (q.size() > 0 && c < 2000) begin
      cycle(0, busy_v, $urandom_range(0, 1023));
      c++;
      if (lat == 0 && (done || err)) lat = c;
    end
    if (lat_exp > 0) chk($sformatf("lat_a%0d", a), 32'(lat), 32'(lat_exp));
  endtask

  function automatic int unsigned pick();
    case ($urandom_range(0, 7))
      0:       return m_cur;
      1, 2:    return m_cur + $urandom_range(1, 3);
      3:       return $urandom_range(MAXA, 1023);
      4, 5:    return $urandom_range(0, 15);
      6:       return $urandom_range(0, MAXA - 1);
      default: return (m_cur > 0) ? m_cur - 1 : 0;
    endcase
  endfunction

  initial begin
    bit r;
    bit v;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    exp_now   = mk(0, 0, 0, 0, 0, 0, 0, 0);

    cycle(1, 0, 0);
    cycle(1, 0, 0);
    cycle(0, 0, 0);

    req(3, 18, 0);
    req(5, 10, 0);
    req(2, 14, 0);
    req(2, 1, 0);
    req(384, 1, 0);
    req(1023, 1, 0);
    cycle(0, 0, 0);

    cycle(1, 0, 0);
    cycle(0, 0, 0);
    req(0, 6, 1);

    // Reset lands during the second increment pulse of A=7 (full mode).
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 1, 7);
    repeat (9) cycle(0, 0, 0);
    chk("inc2_high", 32'(ctrl_sel_inc), 32'(1));
    cycle(1, 0, 0);
    chk("rst_ena", 32'(ctrl_ena), 32'(0));
    chk("rst_inc", 32'(ctrl_sel_inc), 32'(0));
    chk("rst_seln", 32'(ctrl_sel_rst_n), 32'(0));
    chk("rst_cvld", 32'(cur_valid), 32'(0));
    cycle(0, 0, 0);
    req(1, 10, 0);

    repeat (6000) begin
      r = ($urandom_range(0, 299) == 0);
      v = !r && ($urandom_range(0, 2) != 0);
      cycle(r, v, pick());
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/tt_mux_sel_seq.md
Name: tt_mux_sel_seq

Overview:
- Sequencer that drives the serial design-select interface of the multiplexer: select-counter reset, select-increment pulses and mux enable.
- Sits between a host-side request port (SPI/logic-analyser bridge or test FSM) and the mux control wires (ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena).
- A requested tile address becomes a timed pulse train, then enables the selected design.
- Tracks the currently selected address, so forward moves skip the counter reset.

Parameters:
- ADDR_W, 10, width of the design address.
- MAX_ADDR, 384, number of valid addresses (G_X*G_Y). Addresses >= MAX_ADDR are rejected.
- PULSE_W, 2, cycles each ctrl_sel_rst_n low pulse / ctrl_sel_inc high pulse lasts (>=1).
- GAP_W, 2, idle cycles after every pulse (>=1).

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous active-high reset.
- req_addr  in  ADDR_W  target design address.
- req_valid  in  1  request valid.
- req_ready  out  1  block can accept a request.
- done  out  1  one-cycle pulse when a sequence completes.
- err  out  1  one-cycle pulse when a request is rejected.
- cur_addr  out  ADDR_W  currently selected address.
- cur_valid  out  1  cur_addr is meaningful.
- ctrl_sel_rst_n  out  1  select-counter reset, active low.
- ctrl_sel_inc  out  1  select-counter increment; the mux counts rising edges.
- ctrl_ena  out  1  mux enable to the selected design.

Behaviour:
- Reset values: req_ready=0, done=0, err=0, cur_addr=0, cur_valid=0, ctrl_sel_rst_n=0 (counter held in reset), ctrl_sel_inc=0, ctrl_ena=0.
- First cycle after rst low: FSM is in IDLE; req_ready=1 and ctrl_sel_rst_n=1.
- All outputs are registered.
- Handshake: a request is accepted on a clk edge with req_valid&&req_ready. req_ready=1 only in IDLE. req_addr is sampled at accept.
- Decision at accept, with A = req_addr:
  - A>=MAX_ADDR: err pulses next cycle. No output or state change; stays IDLE.
  - cur_valid && A==cur_addr: done pulses next cycle. ctrl_ena unchanged (no glitch); stays IDLE.
  - cur_valid && A>cur_addr: incremental mode. N=A-cur_addr; the reset phase is skipped.
  - Otherwise: full mode. Counter reset phase runs, then N=A.
- FSM states: IDLE -> DIS -> RST -> RGAP -> INC -> IGAP -> ENA -> IDLE.
  - DIS, 1 cycle: ctrl_ena=0, cur_valid=0.
  - RST, PULSE_W cycles: ctrl_sel_rst_n=0. Full mode only.
  - RGAP, GAP_W cycles: ctrl_sel_rst_n=1. Full mode only.
  - INC, PULSE_W cycles: ctrl_sel_inc=1.
  - IGAP, GAP_W cycles: ctrl_sel_inc=0, then decrement the remaining count. If the count is nonzero go to INC, else go to ENA.
  - N=0 (full mode, A=0): go directly RGAP -> ENA.
  - ENA, 1 cycle: ctrl_ena=1, cur_addr=A, cur_valid=1, done=1. Next cycle IDLE with req_ready=1.
- Latency: ctrl_ena rises L cycles after the accept edge.
  - Full mode: L = 1 + (PULSE_W+GAP_W) + N*(PULSE_W+GAP_W) + 1.
  - Incremental mode: L = 1 + N*(PULSE_W+GAP_W) + 1.
- Outside active pulses: ctrl_sel_inc is never high and ctrl_sel_rst_n is never low.
- ctrl_ena is 0 at every cycle where ctrl_sel_rst_n=0 or ctrl_sel_inc=1.
- Counters: the remaining-increment counter is ADDR_W bits wide; the pulse/gap timer is clog2(max(PULSE_W,GAP_W))+1 bits.
- Reset mid-sequence: everything returns to reset values the next cycle. cur_valid=0, so the next request uses full mode.
- Simultaneous events: req_valid while busy is ignored (not latched). The requester holds it until req_ready.
- done and err never pulse in the same cycle.

Test Plan:
- Reset, then request A=3, defaults -> ctrl_sel_rst_n low 2 cycles. Then 3 ctrl_sel_inc pulses, each 2 high / 2 low. ctrl_ena and done rise 18 cycles after accept; cur_addr=3, cur_valid=1.
- From cur_addr=3, request A=5 -> no ctrl_sel_rst_n pulse, 2 inc pulses. ctrl_ena drops 1 cycle after accept and rises 10 cycles after accept; cur_addr=5.
- From cur_addr=5, request A=2 -> full mode: rst pulse plus 2 incs, ctrl_ena rises 14 cycles after accept. Then request A=2 again -> done next cycle, ctrl_ena stays 1 throughout.
- Request A=384 and A=1023 -> err pulse 1 cycle each; outputs unchanged, req_ready returns to 1.
- Request A=0 after reset -> rst pulse, no inc pulses, ctrl_ena rises 6 cycles after accept. Assert req_valid every cycle during the sequence -> no second accept until req_ready=1.
- Assert rst during the 2nd inc pulse of A=7 -> next cycle ctrl_ena=0, ctrl_sel_inc=0, ctrl_sel_rst_n=0, cur_valid=0. A following A=1 request runs full mode.
